// File: rtl/tdm_demux4.sv
// 4-channel TDM receiver: aligns on the slot-0 sync marker and presents a full frame with a strobe.
// Optional: define TDM_ERR_CNT_EN to add a saturating 8-bit alignment error counter (err_cnt).
`timescale 1ns/1ps
module tdm_demux4 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_sync,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic             frame_valid,
`ifdef TDM_ERR_CNT_EN
  output logic [7:0]       err_cnt,
`endif
  output logic [1:0]       slot,
  output logic             locked,
  output logic             sync_err
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q;
  logic [1:0]       cnt_q;
  logic [WIDTH-1:0] sa_q, sb_q, sc_q;
  logic [WIDTH-1:0] a_q, b_q, c_q, d_q;
  logic             fv_q, serr_q;
`ifdef TDM_ERR_CNT_EN
  logic [7:0]       err_cnt_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 2'd0;
      sa_q      <= '0;
      sb_q      <= '0;
      sc_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= '0;
      d_q       <= '0;
      fv_q      <= 1'b0;
      serr_q    <= 1'b0;
`ifdef TDM_ERR_CNT_EN
      err_cnt_q <= 8'd0;
`endif
    end else begin
      fv_q   <= 1'b0;
      serr_q <= 1'b0;
      if (in_valid) begin
        case (state_q)
          IDLE: begin
            // Non-sync samples while hunting for alignment are silently dropped.
            if (in_sync) begin
              sa_q    <= in_data;
              cnt_q   <= 2'd1;
              state_q <= RUN;
            end
          end
          RUN: begin
            if (in_sync) begin
              // A sync anywhere but slot 0 restarts the frame; the partial frame is lost.
              if (cnt_q != 2'd0) begin
                serr_q <= 1'b1;
`ifdef TDM_ERR_CNT_EN
                if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
`endif
              end
              sa_q  <= in_data;
              cnt_q <= 2'd1;
            end else begin
              case (cnt_q)
                2'd0: begin
                  serr_q  <= 1'b1;
                  state_q <= IDLE;
                  cnt_q   <= 2'd0;
`ifdef TDM_ERR_CNT_EN
                  if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
`endif
                end
                2'd1: begin
                  sb_q  <= in_data;
                  cnt_q <= 2'd2;
                end
                2'd2: begin
                  sc_q  <= in_data;
                  cnt_q <= 2'd3;
                end
                default: begin
                  a_q   <= sa_q;
                  b_q   <= sb_q;
                  c_q   <= sc_q;
                  d_q   <= in_data;
                  fv_q  <= 1'b1;
                  cnt_q <= 2'd0;
                end
              endcase
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign a           = a_q;
  assign b           = b_q;
  assign c           = c_q;
  assign d           = d_q;
  assign frame_valid = fv_q;
  assign sync_err    = serr_q;
  assign slot        = cnt_q;
  assign locked      = (state_q == RUN);
`ifdef TDM_ERR_CNT_EN
  assign err_cnt     = err_cnt_q;
`endif

endmodule

// File: doc/tdm_demux4.md
Name: tdm_demux4

Overview:
- Receive-side counterpart of the 4:1 selector. Accepts a time-division-multiplexed stream carrying four channels (a, b, c, d) in slot order 00, 01, 10, 11, as produced by a selector scanned by a 2-bit counter.
- Tracks frame alignment using a sync marker on slot 0.
- Collects each channel's sample and presents all four channels together with a one-cycle frame strobe.
- Sits between the serial link and the parallel channel consumers.

Parameters:
- WIDTH, 1, bit width of each channel sample and of in_data.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data holds a sample this cycle.
- in_sync  input  1  qualifies the current sample as slot 0 (channel a); ignored unless in_valid=1.
- in_data  input  WIDTH  sample value.
- a  output  WIDTH  channel a (slot 00) of the last complete frame.
- b  output  WIDTH  channel b (slot 01) of the last complete frame.
- c  output  WIDTH  channel c (slot 10) of the last complete frame.
- d  output  WIDTH  channel d (slot 11) of the last complete frame.
- frame_valid  output  1  one-cycle pulse: a..d updated this cycle.
- slot  output  2  slot expected for the next accepted sample.
- locked  output  1  1 in RUN state.
- sync_err  output  1  one-cycle pulse on an alignment violation.

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: a=b=c=d=0, shadow registers = 0, frame_valid=0, sync_err=0, slot=0, locked=0, state=IDLE.
- Reset asserted mid-frame: reset values apply immediately; no frame_valid is produced from the partial frame.
- Internal storage: shadow registers sa, sb, sc (WIDTH each); 2-bit slot counter cnt. The slot output is driven by cnt.
- Timing: all outputs are registered. frame_valid and sync_err pulse for exactly one cycle, the cycle after the edge that accepted the triggering sample.
- Cycles with in_valid=0: no state change. Gaps between samples are allowed anywhere in a frame.
- IDLE state:
  - in_valid & in_sync: sa<=in_data, cnt<=1, go to RUN.
  - in_valid & !in_sync: sample discarded, no error.
- RUN, in_valid & in_sync & cnt==0: sa<=in_data, cnt<=1. Normal frame start.
- RUN, in_valid & in_sync & cnt!=0 (early sync):
  - Partial frame discarded; a..d unchanged.
  - sync_err pulses.
  - sa<=in_data, cnt<=1; stay in RUN.
- RUN, in_valid & !in_sync & cnt==0 (missing sync):
  - Sample discarded; sync_err pulses.
  - Go to IDLE, cnt<=0.
- RUN, in_valid & !in_sync & cnt==1: sb<=in_data, cnt<=2.
- RUN, in_valid & !in_sync & cnt==2: sc<=in_data, cnt<=3.
- RUN, in_valid & !in_sync & cnt==3 (frame complete):
  - a<=sa, b<=sb, c<=sc, d<=in_data, all on the same edge.
  - frame_valid pulses; cnt wraps to 0.
- RUN, in_valid & in_sync & cnt==3: treated as an early sync (see above); the frame is not completed.
- Back-to-back frames at full rate (in_valid held high): one frame_valid every 4 cycles.
- Outputs a..d change only on frame_valid and are never partially updated.
- locked = (state==RUN).

Optional Feature:
- Macro: TDM_ERR_CNT_EN.
- Defined: adds output err_cnt (8 bits), reset 0, incremented on every sync_err pulse. It saturates at 255 and clears only on reset.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then with WIDTH=4 send samples 3,5,9,C (sync on the first) with in_valid held high -> one cycle after the 4th sample: frame_valid=1, a=3, b=5, c=9, d=C; slot back to 0; locked=1.
- Same frame with in_valid=0 gaps of 2 cycles between samples -> identical a..d; frame_valid only once, after the 4th sample.
- Send sync+1, 2, then sync+7, 8, 9, A -> sync_err pulses once; a..d stay at the previous frame's values until frame_valid with a=7, b=8, c=9, d=A.
- After a complete frame, send a non-sync sample 6 -> sync_err=1, locked=0; later non-sync samples are ignored with no error; a sync then restores lock.
- Assert rst_n=0 asynchronously after 2 samples of a frame -> outputs zero immediately, locked=0; after release, 2 further non-sync samples produce no frame_valid.
- With TDM_ERR_CNT_EN defined, inject 300 alignment errors -> err_cnt saturates at 255.
